// File: rtl/bomb_stage_1_ctrl.sv
// Stage-1 bomb game controller: arms on start, runs a per-second countdown,
// and resolves wire cuts into SUCCESS or FAILURE for the border renderer.
//
// state     | meaning
// ----------+-----------------------------------------------------
// WAITING   | idle, armed by a start edge only while no wire is cut
// COUNTDOWN | prescaler running, seconds_left decrementing
// SUCCESS   | correct wire cut first, terminal until rst
// FAILURE   | wrong wire cut or timer expired, terminal until rst
module bomb_stage_1_ctrl #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int COUNT_SECONDS = 30,
  parameter int CORRECT_WIRE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] wire_cut,
  output logic [1:0] state,
  output logic [5:0] seconds_left,
  output logic       tick
);

  localparam int              PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_LAST   = PW'(CLK_HZ - 1);
  localparam logic [5:0]      SECS_INIT    = 6'(COUNT_SECONDS);
  localparam logic [3:0]      CORRECT_MASK = 4'(1 << CORRECT_WIRE);

  localparam logic [1:0] WAITING   = 2'd0;
  localparam logic [1:0] COUNTDOWN = 2'd1;
  localparam logic [1:0] SUCCESS   = 2'd2;
  localparam logic [1:0] FAILURE   = 2'd3;

  logic          start_s1, start_s2, start_prev;
  logic [3:0]    cut_s1, cut_s2, cut_prev;
  logic [PW-1:0] presc;

  logic       start_rise;
  logic [3:0] cut_rise;
  logic       wrong_cut;
  logic       right_cut;
  logic       wrap;

  // Two-flop synchronizers followed by a registered copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      cut_s1     <= 4'b0;
      cut_s2     <= 4'b0;
      cut_prev   <= 4'b0;
    end else begin
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      cut_s1     <= wire_cut;
      cut_s2     <= cut_s1;
      cut_prev   <= cut_s2;
    end
  end

  assign start_rise = start_s2 & ~start_prev;
  assign cut_rise   = cut_s2 & ~cut_prev;
  assign wrong_cut  = |(cut_rise & ~CORRECT_MASK);
  assign right_cut  = |(cut_rise & CORRECT_MASK);
  assign wrap       = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAITING;
      seconds_left <= SECS_INIT;
      tick         <= 1'b0;
      presc        <= '0;
    end else begin
      case (state)
        WAITING: begin
          tick <= 1'b0;
          if (start_rise && (cut_s2 == 4'b0)) begin
            state        <= COUNTDOWN;
            seconds_left <= SECS_INIT;
            presc        <= '0;
          end
        end
        COUNTDOWN: begin
          presc <= wrap ? '0 : presc + PW'(1);
          // Cuts outrank the timer, so a cut on the final wrap keeps seconds_left at 1.
          if (wrong_cut) begin
            state <= FAILURE;
            tick  <= 1'b0;
          end else if (right_cut) begin
            state <= SUCCESS;
            tick  <= 1'b0;
          end else if (wrap && (seconds_left == 6'd1)) begin
            state        <= FAILURE;
            seconds_left <= 6'd0;
            tick         <= 1'b1;
          end else if (wrap && (seconds_left >= 6'd2)) begin
            seconds_left <= seconds_left - 6'd1;
            tick         <= 1'b1;
          end else begin
            tick <= 1'b0;
          end
        end
        default: begin
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_stage_1_ctrl.sv
// Directed bench for bomb_stage_1_ctrl (CLK_HZ=4, COUNT_SECONDS=3, CORRECT_WIRE=2)
// with a queue of expected {state, seconds_left, tick} snapshots.
module tb_bomb_stage_1_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] wire_cut;
  logic [1:0] state;
  logic [5:0] seconds_left;
  logic       tick;

  int n_checks;
  int n_fail;
  int tick_count;
  int tick_base;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [5:0] secs;
    logic       tk;
  } exp_t;

  exp_t sb[$];

  bomb_stage_1_ctrl #(
    .CLK_HZ(4),
    .COUNT_SECONDS(3),
    .CORRECT_WIRE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .wire_cut(wire_cut),
    .state(state),
    .seconds_left(seconds_left),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tick === 1'b1) tick_count++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic [5:0] secs,
                      input logic tk);
    exp_t e;
    e.tag = tag; e.st = st; e.secs = secs; e.tk = tk;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert ({state, seconds_left, tick} === {e.st, e.secs, e.tk})
    else begin
      n_fail++;
      $error("FAIL %s: observed state=%0d secs=%0d tick=%0b expected state=%0d secs=%0d tick=%0b",
             e.tag, state, seconds_left, tick, e.st, e.secs, e.tk);
    end
  endtask

  task automatic stepchk(input int n, input string tag, input logic [1:0] st,
                         input logic [5:0] secs, input logic tk);
    push(tag, st, secs, tk);
    step(n);
    pop_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    wire_cut = 4'b0;
    step(3);
    rst = 1'b0;
    stepchk(1, "reset", 2'd0, 6'd3, 1'b0);
  endtask

  // Start sampled at the next edge N; COUNTDOWN is entered at edge N+2.
  task automatic arm(input string tag);
    start = 1'b1;
    stepchk(2, {tag, "_arm_wait"}, 2'd0, 6'd3, 1'b0);
    stepchk(1, {tag, "_arm_enter"}, 2'd1, 6'd3, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    tick_count = 0;
    rst = 1'b1;
    start = 1'b0;
    wire_cut = 4'b0;

    do_reset();

    // Timeout: 3 -> 2 -> 1 -> 0 at 4-cycle spacing, FAILURE at E+12.
    arm("to");
    tick_base = tick_count;
    stepchk(3, "to_pre1", 2'd1, 6'd3, 1'b0);
    stepchk(1, "to_dec1", 2'd1, 6'd2, 1'b1);
    stepchk(1, "to_tick1_off", 2'd1, 6'd2, 1'b0);
    stepchk(2, "to_pre2", 2'd1, 6'd2, 1'b0);
    stepchk(1, "to_dec2", 2'd1, 6'd1, 1'b1);
    stepchk(3, "to_pre3", 2'd1, 6'd1, 1'b0);
    stepchk(1, "to_expire", 2'd3, 6'd0, 1'b1);
    stepchk(1, "to_tick3_off", 2'd3, 6'd0, 1'b0);
    stepchk(8, "to_terminal", 2'd3, 6'd0, 1'b0);
    n_checks++;
    assert (tick_count - tick_base == 3)
    else begin
      n_fail++;
      $error("FAIL to_tick_count: observed %0d expected 3", tick_count - tick_base);
    end

    // Correct cut while seconds_left is 2.
    do_reset();
    arm("cc");
    stepchk(4, "cc_dec1", 2'd1, 6'd2, 1'b1);
    wire_cut = 4'b0100;
    stepchk(2, "cc_wait", 2'd1, 6'd2, 1'b0);
    stepchk(1, "cc_success", 2'd2, 6'd2, 1'b0);
    wire_cut = 4'b1111;
    stepchk(12, "cc_frozen", 2'd2, 6'd2, 1'b0);

    // Wrong and correct wire rising in the same cycle.
    do_reset();
    arm("sim");
    wire_cut = 4'b0101;
    stepchk(2, "sim_wait", 2'd1, 6'd3, 1'b0);
    stepchk(1, "sim_failure", 2'd3, 6'd3, 1'b0);
    stepchk(6, "sim_frozen", 2'd3, 6'd3, 1'b0);

    // Correct cut landing on the final wrap beats the timeout.
    do_reset();
    arm("cvt");
    stepchk(8, "cvt_dec2", 2'd1, 6'd1, 1'b1);
    stepchk(1, "cvt_pre", 2'd1, 6'd1, 1'b0);
    wire_cut = 4'b0100;
    stepchk(2, "cvt_wait", 2'd1, 6'd1, 1'b0);
    stepchk(1, "cvt_success", 2'd2, 6'd1, 1'b0);
    stepchk(8, "cvt_frozen", 2'd2, 6'd1, 1'b0);

    // Wire held cut through reset blocks arming.
    rst = 1'b1;
    start = 1'b0;
    wire_cut = 4'b0001;
    step(3);
    rst = 1'b0;
    step(2);
    start = 1'b1;
    stepchk(1, "blk_pulse", 2'd0, 6'd3, 1'b0);
    start = 1'b0;
    stepchk(6, "blk_waiting", 2'd0, 6'd3, 1'b0);
    wire_cut = 4'b0000;
    step(3);
    arm("mid");
    stepchk(5, "mid_dec1", 2'd1, 6'd2, 1'b0);
    #2;
    rst = 1'b1;
    push("mid_async_rst", 2'd0, 6'd3, 1'b0);
    #1;
    pop_check();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
